// File: rtl/trig_lut_sched_if.sv
// rtl/trig_lut_sched_if.sv - request/response bundle between trig requesters and the LUT scheduler
interface trig_lut_sched_if;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_op0;
   logic [1:0]  req_op1;
   logic [31:0] req_angle0;
   logic [31:0] req_angle1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_sin;
   logic [31:0] rsp_cos;
   logic        rsp_err;

   modport master (
      output req_valid, req_op0, req_op1, req_angle0, req_angle1, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sin, rsp_cos, rsp_err
   );

   modport slave (
      input  req_valid, req_op0, req_op1, req_angle0, req_angle1, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sin, rsp_cos, rsp_err
   );
endinterface

// File: rtl/trig_lut_sched.sv
// rtl/trig_lut_sched.sv - round-robin scheduler sharing one sin/cos LUT between two requesters
// Optional angle range check: define TRIG_LUT_RANGE_CHECK_EN.
module trig_lut_sched #(
   parameter int unsigned ANGLE_MAX = 360
) (
   input  logic              clk,
   input  logic              rst,
   trig_lut_sched_if.slave   bus,
   output logic              lut_op_selector,
   output logic [31:0]       lut_angle,
   input  logic [31:0]       lut_value
);

`ifdef TRIG_LUT_RANGE_CHECK_EN
   localparam bit RANGE_CHECK = 1'b1;
`else
   localparam bit RANGE_CHECK = 1'b0;
`endif

   localparam logic [1:0] OP_SIN  = 2'b00;
   localparam logic [1:0] OP_COS  = 2'b01;
   localparam logic [1:0] OP_BOTH = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   typedef enum logic [1:0] {IDLE, LOOK1, LOOK2, RESP} state_t;

   state_t      state, state_nx;
   logic        last_grant;
   logic        grant;
   logic        accept;
   logic        reject;
   logic [1:0]  op_sel;
   logic [31:0] angle_sel;
   logic [1:0]  op_r;
   logic        id_r;
   logic [31:0] sin_r;
   logic [31:0] cos_r;
   logic        err_r;
   logic        sel_r;
   logic [31:0] angle_r;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // A tie goes to whoever was not granted last; a lone requester always wins.
   always_comb begin
      grant         = 1'b0;
      accept        = 1'b0;
      bus.req_ready = 2'b00;
      state_nx      = state;
      case (bus.req_valid)
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant;
         default: grant = 1'b0;
      endcase
      op_sel    = grant ? bus.req_op1    : bus.req_op0;
      angle_sel = grant ? bus.req_angle1 : bus.req_angle0;
      reject    = (op_sel == OP_RSVD) | (RANGE_CHECK & (angle_sel > ANGLE_MAX));
      case (state)
         IDLE: begin
            if (|bus.req_valid) begin
               accept        = 1'b1;
               bus.req_ready = grant ? 2'b10 : 2'b01;
               state_nx      = reject ? RESP : LOOK1;
            end
         end
         LOOK1:   state_nx = (op_r == OP_BOTH) ? LOOK2 : RESP;
         LOOK2:   state_nx = RESP;
         RESP:    if (bus.rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         op_r       <= OP_SIN;
         id_r       <= 1'b0;
         sin_r      <= '0;
         cos_r      <= '0;
         err_r      <= 1'b0;
         sel_r      <= 1'b0;
         angle_r    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  id_r  <= grant;
                  op_r  <= op_sel;
                  sin_r <= '0;
                  cos_r <= '0;
                  err_r <= reject;
                  // Rejected requests never touch the LUT inputs.
                  if (!reject) begin
                     angle_r <= angle_sel;
                     sel_r   <= (op_sel == OP_COS);
                  end
               end
            end
            LOOK1: begin
               if (op_r == OP_COS) cos_r <= lut_value;
               else                sin_r <= lut_value;
               if (op_r == OP_BOTH) begin
                  sel_r <= 1'b1;
               end else begin
                  sel_r   <= 1'b0;
                  angle_r <= '0;
               end
            end
            LOOK2: begin
               cos_r   <= lut_value;
               sel_r   <= 1'b0;
               angle_r <= '0;
            end
            RESP: begin
               if (bus.rsp_ready) last_grant <= id_r;
            end
            default: ;
         endcase
      end
   end

   assign bus.rsp_valid   = (state == RESP);
   assign bus.rsp_id      = id_r;
   assign bus.rsp_sin     = sin_r;
   assign bus.rsp_cos     = cos_r;
   assign bus.rsp_err     = err_r;
   assign lut_op_selector = sel_r;
   assign lut_angle       = angle_r;

endmodule

// File: tb/tb_trig_lut_sched.sv
// tb/tb_trig_lut_sched.sv - scoreboard bench for trig_lut_sched with a behavioural LUT
module tb_trig_lut_sched;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lut_op_selector;
   logic [31:0] lut_angle;
   logic [31:0] lut_value;

   always #5 clk = ~clk;

   trig_lut_sched_if bus();

   trig_lut_sched #(.ANGLE_MAX(360)) dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus),
      .lut_op_selector (lut_op_selector),
      .lut_angle       (lut_angle),
      .lut_value       (lut_value)
   );

   function automatic logic [31:0] lut_f(input logic sel, input logic [31:0] a);
      return sel ? (32'h4000_0000 | (a * 32'd3)) : (a * 32'd7 + 32'd5);
   endfunction

   assign lut_value = lut_f(lut_op_selector, lut_angle);

   typedef struct packed {
      logic        id;
      logic        err;
      logic [31:0] s;
      logic [31:0] c;
   } exp_t;

   exp_t sb[$];
   int   grant_log[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t got_e;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic id, input logic [1:0] op, input logic [31:0] a);
      exp_t e;
      logic bad;
      e.id = id;
      e.err = 1'b0;
      e.s = '0;
      e.c = '0;
      bad = (op == 2'b11);
`ifdef TRIG_LUT_RANGE_CHECK_EN
      bad = bad | (a > 32'd360);
`endif
      if (bad) e.err = 1'b1;
      else begin
         if (op != 2'b01) e.s = lut_f(1'b0, a);
         if (op != 2'b00) e.c = lut_f(1'b1, a);
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.req_valid[0] && bus.req_ready[0]) begin
            sb.push_back(model(1'b0, bus.req_op0, bus.req_angle0));
            grant_log.push_back(0);
         end
         if (bus.req_valid[1] && bus.req_ready[1]) begin
            sb.push_back(model(1'b1, bus.req_op1, bus.req_angle1));
            grant_log.push_back(1);
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
            else begin
               got_e = sb.pop_front();
               check("sb_id",  {63'd0, bus.rsp_id},  {63'd0, got_e.id});
               check("sb_err", {63'd0, bus.rsp_err}, {63'd0, got_e.err});
               check("sb_sin", {32'd0, bus.rsp_sin}, {32'd0, got_e.s});
               check("sb_cos", {32'd0, bus.rsp_cos}, {32'd0, got_e.c});
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid  = 2'b00;
      bus.req_op0    = 2'b00;
      bus.req_op1    = 2'b00;
      bus.req_angle0 = '0;
      bus.req_angle1 = '0;
      bus.rsp_ready  = 1'b1;
      rst = 1'b1;
      repeat (3) step();
      check("rst_req_ready", {62'd0, bus.req_ready}, 64'd0);
      check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
      check("rst_rsp_id",    {63'd0, bus.rsp_id}, 64'd0);
      check("rst_rsp_sin",   {32'd0, bus.rsp_sin}, 64'd0);
      check("rst_rsp_cos",   {32'd0, bus.rsp_cos}, 64'd0);
      check("rst_rsp_err",   {63'd0, bus.rsp_err}, 64'd0);
      check("rst_lut_sel",   {63'd0, lut_op_selector}, 64'd0);
      check("rst_lut_angle", {32'd0, lut_angle}, 64'd0);
      rst = 1'b0;
      step();

      // single sine from requester 0
      bus.req_op0 = 2'b00; bus.req_angle0 = 32'd30; bus.req_valid = 2'b01;
      #1 check("single_ready", {62'd0, bus.req_ready}, 64'd1);
      step(); bus.req_valid = 2'b00;
      check("single_t1_sel",   {63'd0, lut_op_selector}, 64'd0);
      check("single_t1_angle", {32'd0, lut_angle}, 64'd30);
      check("single_t1_valid", {63'd0, bus.rsp_valid}, 64'd0);
      step();
      check("single_t2_valid", {63'd0, bus.rsp_valid}, 64'd1);
      check("single_t2_id",    {63'd0, bus.rsp_id}, 64'd0);
      check("single_t2_sin",   {32'd0, bus.rsp_sin}, {32'd0, lut_f(1'b0, 32'd30)});
      check("single_t2_cos",   {32'd0, bus.rsp_cos}, 64'd0);
      step();
      check("single_done", {63'd0, bus.rsp_valid}, 64'd0);

      // both from requester 1
      bus.req_op1 = 2'b10; bus.req_angle1 = 32'd90; bus.req_valid = 2'b10;
      step(); bus.req_valid = 2'b00;
      check("both_t1_sel",   {63'd0, lut_op_selector}, 64'd0);
      check("both_t1_angle", {32'd0, lut_angle}, 64'd90);
      step();
      check("both_t2_sel",   {63'd0, lut_op_selector}, 64'd1);
      check("both_t2_angle", {32'd0, lut_angle}, 64'd90);
      check("both_t2_valid", {63'd0, bus.rsp_valid}, 64'd0);
      step();
      check("both_t3_valid", {63'd0, bus.rsp_valid}, 64'd1);
      check("both_t3_id",    {63'd0, bus.rsp_id}, 64'd1);
      check("both_t3_sin",   {32'd0, bus.rsp_sin}, {32'd0, lut_f(1'b0, 32'd90)});
      check("both_t3_cos",   {32'd0, bus.rsp_cos}, {32'd0, lut_f(1'b1, 32'd90)});
      step();

      // round-robin with both requesters always valid
      bus.req_op0 = 2'b01; bus.req_angle0 = 32'd45;
      bus.req_op1 = 2'b00; bus.req_angle1 = 32'd200;
      grant_log.delete();
      bus.req_valid = 2'b11;
      for (int i = 0; i < 60 && grant_log.size() < 4; i++) step();
      bus.req_valid = 2'b00;
      check("rr_count", 64'(grant_log.size()), 64'd4);
      for (int k = 0; k < grant_log.size() && k < 4; k++)
         check($sformatf("rr_grant%0d", k), 64'(grant_log[k]), 64'(k % 2));
      for (int i = 0; i < 20 && sb.size() != 0; i++) step();
      step();
      check("rr_drain", 64'(sb.size()), 64'd0);

      // back-pressure in RESP with requester 1 waiting
      bus.rsp_ready = 1'b0;
      bus.req_op0 = 2'b00; bus.req_angle0 = 32'd10; bus.req_valid = 2'b01;
      step();
      bus.req_op1 = 2'b01; bus.req_angle1 = 32'd77; bus.req_valid = 2'b10;
      step();
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", {63'd0, bus.rsp_valid}, 64'd1);
         check("bp_id",    {63'd0, bus.rsp_id}, 64'd0);
         check("bp_sin",   {32'd0, bus.rsp_sin}, {32'd0, lut_f(1'b0, 32'd10)});
         check("bp_cos",   {32'd0, bus.rsp_cos}, 64'd0);
         check("bp_ready", {62'd0, bus.req_ready}, 64'd0);
         step();
      end
      bus.rsp_ready = 1'b1;
      step();
      check("bp_release_valid", {63'd0, bus.rsp_valid}, 64'd0);
      check("bp_release_ready", {62'd0, bus.req_ready}, 64'd2);
      step(); bus.req_valid = 2'b00;
      repeat (3) step();

      // reserved op
      bus.req_op0 = 2'b11; bus.req_angle0 = 32'd5; bus.req_valid = 2'b01;
      step(); bus.req_valid = 2'b00;
      check("err_valid", {63'd0, bus.rsp_valid}, 64'd1);
      check("err_flag",  {63'd0, bus.rsp_err}, 64'd1);
      check("err_sin",   {32'd0, bus.rsp_sin}, 64'd0);
      check("err_cos",   {32'd0, bus.rsp_cos}, 64'd0);
      check("err_lut_angle", {32'd0, lut_angle}, 64'd0);
      check("err_lut_sel",   {63'd0, lut_op_selector}, 64'd0);
      step();

      // angle just above and at the limit
      bus.req_op0 = 2'b00; bus.req_angle0 = 32'd361; bus.req_valid = 2'b01;
      step(); bus.req_valid = 2'b00;
`ifdef TRIG_LUT_RANGE_CHECK_EN
      check("range361_valid", {63'd0, bus.rsp_valid}, 64'd1);
      check("range361_err",   {63'd0, bus.rsp_err}, 64'd1);
      check("range361_lut",   {32'd0, lut_angle}, 64'd0);
`else
      check("range361_lut",   {32'd0, lut_angle}, 64'd361);
`endif
      repeat (3) step();
      bus.req_op0 = 2'b00; bus.req_angle0 = 32'd360; bus.req_valid = 2'b01;
      step(); bus.req_valid = 2'b00;
      check("range360_lut",   {32'd0, lut_angle}, 64'd360);
      check("range360_valid", {63'd0, bus.rsp_valid}, 64'd0);
      repeat (3) step();

      // reset while in LOOK2
      bus.req_op1 = 2'b10; bus.req_angle1 = 32'd120; bus.req_valid = 2'b10;
      step(); bus.req_valid = 2'b00;
      step();
      check("mid_look2_sel", {63'd0, lut_op_selector}, 64'd1);
      rst = 1'b1;
      step();
      check("mid_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
      check("mid_rsp_id",    {63'd0, bus.rsp_id}, 64'd0);
      check("mid_rsp_sin",   {32'd0, bus.rsp_sin}, 64'd0);
      check("mid_rsp_cos",   {32'd0, bus.rsp_cos}, 64'd0);
      check("mid_lut_sel",   {63'd0, lut_op_selector}, 64'd0);
      check("mid_lut_angle", {32'd0, lut_angle}, 64'd0);
      if (sb.size() != 0) got_e = sb.pop_front();
      rst = 1'b0;
      step();
      check("mid_after_valid", {63'd0, bus.rsp_valid}, 64'd0);
      bus.req_op0 = 2'b00; bus.req_angle0 = 32'd15;
      bus.req_op1 = 2'b01; bus.req_angle1 = 32'd25;
      bus.req_valid = 2'b11;
      #1 check("mid_tie_ready", {62'd0, bus.req_ready}, 64'd1);
      step(); bus.req_valid = 2'b00;
      repeat (4) step();

      check("final_sb_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
